param_bram_writer: RTL and testbench

Loads the model parameter store by packing an incoming byte stream (host link, e.g. UART receive path) into 32-bit words and writing them sequentially into the parameter block RAM (`blk_mem_gen_0` port A) from address 0 upward. It is the writer counterpart of the parameter loader, which reads the same BRAM back into the flattened parameter vector. It sits between the byte-stream source and the BRAM, and raises `done` once all parameters are stored.

---
 rtl/params_pkg.sv | 16 +
 rtl/param_bram_writer_if.sv | 25 ++
 rtl/param_bram_writer_packer.sv | 33 +++
 rtl/param_bram_writer.sv | 88 ++++++++
 tb/tb_param_bram_writer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/params_pkg.sv
// Shared constants and state encoding for the parameter store writer and loader.
package params_pkg;

    localparam int NUM_PARAMS   = 6002;
    localparam int PARAM_ADDR_W = 13;
    localparam int WORD_W       = 32;
    localparam int BYTE_W       = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } wr_state_t;

endpackage

// File: rtl/param_bram_writer_if.sv
// Byte-stream input and BRAM port-A drive bundled for the parameter store writer.
interface param_bram_writer_if #(
    parameter int ADDR_W = 13
);
    import params_pkg::*;

    logic                in_valid;
    logic [BYTE_W-1:0]   in_data;
    logic                in_ready;
    logic                ena;
    logic                wea;
    logic [ADDR_W-1:0]   addra;
    logic [WORD_W-1:0]   dina;

    modport master (
        output in_valid, in_data,
        input  in_ready, ena, wea, addra, dina
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ena, wea, addra, dina
    );

endinterface

// File: rtl/param_bram_writer_packer.sv
// Little-endian byte packer; word/word_full show the completed word in the cycle its last byte arrives.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);
    import params_pkg::*;

    logic [WORD_W-1:0] shreg;
    logic [1:0]        idx;

    // Insert the incoming byte so the top can register the full word on the 4th accept
    always_comb begin
        word             = shreg;
        word[8*idx +: 8] = byte_in;
        word_full        = byte_en && (idx == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg <= '0;
            idx   <= '0;
        end else if (byte_en) begin
            shreg[8*idx +: 8] <= byte_in;
            idx               <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/param_bram_writer.sv
// Packs a byte stream into 32-bit words and writes them to the parameter BRAM from address 0 upward.
module param_bram_writer #(
    parameter int NUM_PARAMS = 6002,
    parameter int ADDR_W     = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    param_bram_writer_if.slave   bus,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    word_count
);
    import params_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PARAMS - 1);

    wr_state_t         state;
    logic              arm;
    logic              byte_en;
    logic [WORD_W-1:0] packed_word;
    logic              word_full;

    // word_count doubles as the next write address since both clear on start and step per write
    assign arm     = start && ((state == S_IDLE) || (state == S_DONE));
    assign byte_en = bus.in_valid && bus.in_ready;

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (arm),
        .byte_en   (byte_en),
        .byte_in   (bus.in_data),
        .word      (packed_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            bus.in_ready <= 1'b0;
            bus.ena      <= 1'b0;
            bus.wea      <= 1'b0;
            bus.addra    <= '0;
            bus.dina     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            word_count   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_COLLECT;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        word_count   <= '0;
                    end
                end
                S_COLLECT: begin
                    if (word_full) begin
                        state        <= S_WRITE;
                        bus.in_ready <= 1'b0;
                        bus.ena      <= 1'b1;
                        bus.wea      <= 1'b1;
                        bus.addra    <= word_count;
                        bus.dina     <= packed_word;
                    end
                end
                S_WRITE: begin
                    bus.ena    <= 1'b0;
                    bus.wea    <= 1'b0;
                    word_count <= word_count + 1'b1;
                    if (bus.addra == LAST_ADDR) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state        <= S_COLLECT;
                        bus.in_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_bram_writer.sv
// Directed bench for param_bram_writer with a 4-word store and a negedge BRAM write monitor.
module tb_param_bram_writer;

    localparam int NP = 4;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int            strobe_err = 0;
    int            done_err = 0;
    logic          prev_ena = 1'b0;
    logic          prev_last = 1'b0;

    param_bram_writer_if #(.ADDR_W(AW)) bus ();

    param_bram_writer #(.NUM_PARAMS(NP), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus.slave),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Record every write strobe and flag multi-cycle strobes or a late done
    always @(negedge clk) begin
        if (bus.ena && bus.wea) begin
            wr_addr.push_back(bus.addra);
            wr_data.push_back(bus.dina);
            if (prev_ena) strobe_err++;
        end
        if (prev_last && !done) done_err++;
        prev_ena  = bus.ena;
        prev_last = bus.ena && bus.wea && (bus.addra == AW'(NP - 1));
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed n consecutive byte values starting at first, idling gap_pct percent of cycles
    task automatic applyStimulus(input logic [7:0] first, input int n, input int gap_pct);
        int sent = 0;
        int budget = 400 * n;
        while (sent < n && budget > 0) begin
            logic acc;
            if ($urandom_range(0, 99) < gap_pct) begin
                bus.in_valid = 1'b0;
                acc = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = first + 8'(sent);
                acc = bus.in_ready;
            end
            tick();
            if (acc) sent++;
            budget--;
        end
        bus.in_valid = 1'b0;
        checkOutput("bytes_sent", 32'(sent), 32'(n));
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone();
        int budget = 50;
        while (!done && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput("done_wait", 32'(done), 32'd1);
    endtask

    logic [31:0] exp_a [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    logic [31:0] exp_b [4] = '{32'h24232221, 32'h28272625, 32'h2C2B2A29, 32'h302F2E2D};

    initial begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (3) tick();

        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_ena", 32'(bus.ena), 32'd0);
        checkOutput("rst_wea", 32'(bus.wea), 32'd0);
        checkOutput("rst_addra", 32'(bus.addra), 32'd0);
        checkOutput("rst_dina", bus.dina, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_word_count", 32'(word_count), 32'd0);

        rst = 1'b0;
        repeat (6) tick();
        checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("idle_no_write", 32'(wr_addr.size()), 32'd0);
        bus.in_valid = 1'b0;

        $display("[TB] back-to-back load");
        pulseStart();
        checkOutput("start_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("start_busy", 32'(busy), 32'd1);
        applyStimulus(8'h01, 16, 0);
        waitDone();
        checkOutput("b2b_word_count", 32'(word_count), 32'd4);
        checkOutput("b2b_busy", 32'(busy), 32'd0);
        checkOutput("b2b_writes", 32'(wr_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("b2b_addr%0d", i), 32'(wr_addr[i]), 32'(i));
            checkOutput($sformatf("b2b_data%0d", i), wr_data[i], exp_a[i]);
        end

        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (4) tick();
        bus.in_valid = 1'b0;
        checkOutput("done_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("done_no_write", 32'(wr_addr.size()), 32'd4);
        checkOutput("done_held", 32'(done), 32'd1);

        $display("[TB] re-arm and gapped load with ignored mid-word start");
        wr_addr.delete();
        wr_data.delete();
        pulseStart();
        checkOutput("rearm_done", 32'(done), 32'd0);
        checkOutput("rearm_word_count", 32'(word_count), 32'd0);
        applyStimulus(8'h01, 2, 0);
        pulseStart();
        checkOutput("mid_start_busy", 32'(busy), 32'd1);
        checkOutput("mid_start_word_count", 32'(word_count), 32'd0);
        applyStimulus(8'h03, 14, 30);
        waitDone();
        checkOutput("gap_word_count", 32'(word_count), 32'd4);
        checkOutput("gap_writes", 32'(wr_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("gap_addr%0d", i), 32'(wr_addr[i]), 32'(i));
            checkOutput($sformatf("gap_data%0d", i), wr_data[i], exp_a[i]);
        end

        $display("[TB] reset during a partial word");
        wr_addr.delete();
        wr_data.delete();
        pulseStart();
        applyStimulus(8'h61, 10, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("prst_writes", 32'(wr_addr.size()), 32'd2);
        checkOutput("prst_addra", 32'(bus.addra), 32'd0);
        checkOutput("prst_busy", 32'(busy), 32'd0);
        checkOutput("prst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("prst_word_count", 32'(word_count), 32'd0);

        wr_addr.delete();
        wr_data.delete();
        pulseStart();
        applyStimulus(8'h21, 16, 10);
        waitDone();
        checkOutput("reload_writes", 32'(wr_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("reload_addr%0d", i), 32'(wr_addr[i]), 32'(i));
            checkOutput($sformatf("reload_data%0d", i), wr_data[i], exp_b[i]);
        end

        checkOutput("strobe_single_cycle", 32'(strobe_err), 32'd0);
        checkOutput("done_after_last_write", 32'(done_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
